// File: rtl/tenthirty_table.sv
// Ten-and-a-half table controller: deals from an external card source, sequences
// player/dealer turns, scores hands in half-points and reports per-player wins.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for any button to start a round
// DEAL     | one card to each seat 0..NUM_PLAYERS, dealer last
// WAIT_ACT | current seat chooses hit or stand
// DRAW     | fetch one card for the current seat
// NEXT     | advance to next seat, or score the round after the dealer
// RESULT   | win bitmap valid, waiting for stand to acknowledge
// DONE     | match complete, terminal until reset
module tenthirty_table #(
   parameter int NUM_PLAYERS = 2,
   parameter int MAX_CARDS   = 5,
   parameter int TARGET_HALF = 21,
   parameter int GAMES       = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         btn_hit,
   input  logic                         btn_stand,
   output logic                         card_req,
   input  logic                         card_vld,
   input  logic [3:0]                   card_num,
   output logic [2:0]                   seat_ptr,
   output logic [6*(NUM_PLAYERS+1)-1:0] score_all,
   output logic [2:0]                   cards_cur,
   output logic [NUM_PLAYERS-1:0]       win,
   output logic                         result_vld,
   output logic [3:0]                   game_cnt,
   output logic                         done
);

   localparam int NS = NUM_PLAYERS + 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_DEAL   = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_DRAW   = 3'd3;
   localparam logic [2:0] S_NEXT   = 3'd4;
   localparam logic [2:0] S_RESULT = 3'd5;
   localparam logic [2:0] S_DONE   = 3'd6;

   localparam logic [2:0] DEALER = 3'(NUM_PLAYERS);
   localparam logic [5:0] TGT    = 6'(TARGET_HALF);
   localparam logic [2:0] MAXC   = 3'(MAX_CARDS);
   localparam logic [3:0] NGAMES = 4'(GAMES);

   logic [2:0] state;
   logic [5:0] score [8];
   logic [2:0] cards [8];
   logic       cap_vld;
   logic [5:0] cap_val;

   logic                   card_ok;
   logic [5:0]             card_val;
   logic [5:0]             score_nxt;
   logic [2:0]             cards_nxt;
   logic [NUM_PLAYERS-1:0] win_nxt;
   logic [3:0]             game_nxt;

   always_comb begin
      card_ok   = (card_num != 4'd0) && (card_num <= 4'd13);
      card_val  = (card_num <= 4'd10) ? {1'b0, card_num, 1'b0} : 6'd1;
      score_nxt = score[seat_ptr] + cap_val;
      cards_nxt = cards[seat_ptr] + 3'd1;
      cards_cur = cards[seat_ptr];
      game_nxt  = game_cnt + 4'd1;
   end

   // Tie goes to the dealer; a busted player never wins.
   always_comb begin
      win_nxt = '0;
      for (int k = 0; k < NUM_PLAYERS; k++) begin
         win_nxt[k] = (score[3'(k)] <= TGT) &&
                      ((score[DEALER] > TGT) || (score[3'(k)] > score[DEALER]));
      end
   end

   always_comb begin
      score_all = '0;
      for (int k = 0; k < NS; k++) begin
         score_all[6*k +: 6] = score[3'(k)];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         card_req   <= 1'b0;
         cap_vld    <= 1'b0;
         cap_val    <= '0;
         seat_ptr   <= '0;
         win        <= '0;
         result_vld <= 1'b0;
         game_cnt   <= '0;
         done       <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            score[i] <= '0;
            cards[i] <= '0;
         end
      end else begin
         case (state)
            S_IDLE: begin
               if (btn_hit || btn_stand) begin
                  for (int i = 0; i < 8; i++) begin
                     score[i] <= '0;
                     cards[i] <= '0;
                  end
                  seat_ptr <= '0;
                  state    <= S_DEAL;
               end
            end
            S_DEAL, S_DRAW: begin
               // Captured card is applied one cycle after the handshake.
               if (card_req) begin
                  if (card_vld && card_ok) begin
                     card_req <= 1'b0;
                     cap_vld  <= 1'b1;
                     cap_val  <= card_val;
                  end
               end else if (cap_vld) begin
                  cap_vld          <= 1'b0;
                  score[seat_ptr]  <= score_nxt;
                  cards[seat_ptr]  <= cards_nxt;
                  if (state == S_DEAL) begin
                     if (seat_ptr == DEALER) begin
                        seat_ptr <= '0;
                        state    <= S_WAIT;
                     end else begin
                        seat_ptr <= seat_ptr + 3'd1;
                     end
                  end else if ((score_nxt > TGT) || (cards_nxt == MAXC)) begin
                     state <= S_NEXT;
                  end else begin
                     state <= S_WAIT;
                  end
               end else begin
                  card_req <= 1'b1;
               end
            end
            S_WAIT: begin
               if (btn_hit) begin
                  state <= S_DRAW;
               end else if (btn_stand) begin
                  state <= S_NEXT;
               end
            end
            S_NEXT: begin
               if (seat_ptr == DEALER) begin
                  state      <= S_RESULT;
                  result_vld <= 1'b1;
                  win        <= win_nxt;
               end else begin
                  seat_ptr <= seat_ptr + 3'd1;
                  state    <= S_WAIT;
               end
            end
            S_RESULT: begin
               if (btn_stand) begin
                  game_cnt   <= game_nxt;
                  result_vld <= 1'b0;
                  win        <= '0;
                  if (game_nxt == NGAMES) begin
                     state <= S_DONE;
                     done  <= 1'b1;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end
            S_DONE: begin
               done <= 1'b1;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tenthirty_table.sv
// Directed bench for tenthirty_table: round results go through a scoreboard queue,
// handshake/sequencing details are checked inline.
module tb_tenthirty_table;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        btn_hit = 1'b0;
   logic        btn_stand = 1'b0;
   logic        card_req;
   logic        card_vld = 1'b0;
   logic [3:0]  card_num = 4'd0;
   logic [2:0]  seat_ptr;
   logic [17:0] score_all;
   logic [2:0]  cards_cur;
   logic [1:0]  win;
   logic        result_vld;
   logic [3:0]  game_cnt;
   logic        done;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [1:0]  win;
      logic [17:0] scores;
   } exp_t;
   exp_t sb_q[$];
   exp_t sb_e;
   logic rv_d = 1'b0;

   tenthirty_table #(.NUM_PLAYERS(2), .MAX_CARDS(5), .TARGET_HALF(21), .GAMES(4)) dut (
      .clk(clk), .rst(rst), .btn_hit(btn_hit), .btn_stand(btn_stand),
      .card_req(card_req), .card_vld(card_vld), .card_num(card_num),
      .seat_ptr(seat_ptr), .score_all(score_all), .cards_cur(cards_cur),
      .win(win), .result_vld(result_vld), .game_cnt(game_cnt), .done(done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: compare round outcome whenever the DUT presents a result.
   always @(negedge clk) begin
      if (result_vld && !rv_d) begin
         if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_empty: result seen with no expectation queued");
         end else begin
            sb_e = sb_q.pop_front();
            chk("win", {30'd0, win}, {30'd0, sb_e.win});
            chk("scores", {14'd0, score_all}, {14'd0, sb_e.scores});
         end
      end
      rv_d <= result_vld;
   end

   task automatic wait_req();
      int t = 0;
      while (!card_req && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("req_wait", {31'd0, card_req}, 32'd1);
   endtask

   task automatic give_card(input logic [3:0] r);
      wait_req();
      card_vld = 1'b1;
      card_num = r;
      @(negedge clk);
      card_vld = 1'b0;
      card_num = 4'd0;
      chk("req_drop", {31'd0, card_req}, 32'd0);
      @(negedge clk);
   endtask

   task automatic give_bad(input logic [3:0] r);
      wait_req();
      card_vld = 1'b1;
      card_num = r;
      @(negedge clk);
      card_vld = 1'b0;
      card_num = 4'd0;
      chk("bad_req_held", {31'd0, card_req}, 32'd1);
      chk("bad_no_card", {29'd0, cards_cur}, 32'd0);
   endtask

   task automatic press(input logic h, input logic s);
      @(negedge clk);
      btn_hit   = h;
      btn_stand = s;
      @(negedge clk);
      btn_hit   = 1'b0;
      btn_stand = 1'b0;
   endtask

   task automatic start_game();
      press(1'b1, 1'b0);
      chk("req_entry", {31'd0, card_req}, 32'd0);
      @(negedge clk);
      chk("req_rise", {31'd0, card_req}, 32'd1);
   endtask

   task automatic finish_round(input logic [3:0] exp_cnt);
      int t = 0;
      while (!result_vld && t < 20) begin
         @(negedge clk);
         t++;
      end
      chk("result_vld", {31'd0, result_vld}, 32'd1);
      press(1'b0, 1'b1);
      chk("game_cnt", {28'd0, game_cnt}, {28'd0, exp_cnt});
      chk("result_clr", {29'd0, result_vld, win}, 32'd0);
   endtask

   initial begin
      // Reset mid-DRAW with a card request outstanding
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_init", {14'd0, card_req, seat_ptr, cards_cur, win, result_vld, game_cnt, done},
          32'd0);
      start_game();
      give_card(4'd3); give_card(4'd7); give_card(4'd13);
      press(1'b1, 1'b0);
      @(negedge clk);
      chk("req_draw", {31'd0, card_req}, 32'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_req", {31'd0, card_req}, 32'd0);
      chk("rst_scores", {14'd0, score_all}, 32'd0);
      chk("rst_misc", {20'd0, seat_ptr, cards_cur, win, result_vld, game_cnt, done}, 32'd0);

      // Round 1: 3,7,K; P0 stands, P1 hits 2, dealer stands at 1
      start_game();
      give_card(4'd3); give_card(4'd7); give_card(4'd13);
      chk("deal_seat", {29'd0, seat_ptr}, 32'd0);
      chk("deal_cards", {29'd0, cards_cur}, 32'd1);
      press(1'b0, 1'b1);
      press(1'b1, 1'b0);
      give_card(4'd2);
      chk("r1_seat", {29'd0, seat_ptr}, 32'd1);
      chk("r1_cards", {29'd0, cards_cur}, 32'd2);
      press(1'b0, 1'b1);
      sb_q.push_back('{win: 2'b11, scores: {6'd1, 6'd18, 6'd6}});
      press(1'b0, 1'b1);
      finish_round(4'd1);

      // Round 2: busts advance without stand; dealer bust does not save busted P0
      start_game();
      give_card(4'd9); give_card(4'd5); give_card(4'd10);
      press(1'b1, 1'b0);
      give_card(4'd2);
      @(negedge clk);
      chk("bust_adv", {29'd0, seat_ptr}, 32'd1);
      press(1'b0, 1'b1);
      press(1'b1, 1'b0);
      sb_q.push_back('{win: 2'b10, scores: {6'd24, 6'd10, 6'd22}});
      give_card(4'd2);
      finish_round(4'd2);

      // Round 3: five court cards force a stand; 20 vs 20 tie to dealer
      start_game();
      give_card(4'd11); give_card(4'd10); give_card(4'd10);
      press(1'b1, 1'b0); give_card(4'd12);
      press(1'b1, 1'b0); give_card(4'd13);
      press(1'b1, 1'b0); give_card(4'd11);
      chk("four_cards", {26'd0, seat_ptr, cards_cur}, {26'd0, 3'd0, 3'd4});
      press(1'b1, 1'b0); give_card(4'd12);
      @(negedge clk);
      chk("max_adv", {29'd0, seat_ptr}, 32'd1);
      press(1'b0, 1'b1);
      sb_q.push_back('{win: 2'b00, scores: {6'd20, 6'd20, 6'd5}});
      press(1'b0, 1'b1);
      finish_round(4'd3);

      // Round 4: bad ranks dropped, stalled source, hit+stand together draws
      start_game();
      give_bad(4'd0);
      give_bad(4'd14);
      repeat (10) @(negedge clk);
      chk("stall_req", {31'd0, card_req}, 32'd1);
      chk("stall_seat", {29'd0, seat_ptr}, 32'd0);
      give_card(4'd5); give_card(4'd4); give_card(4'd6);
      press(1'b1, 1'b1);
      give_card(4'd2);
      chk("both_draw", {26'd0, seat_ptr, cards_cur}, {26'd0, 3'd0, 3'd2});
      press(1'b0, 1'b1);
      press(1'b0, 1'b1);
      sb_q.push_back('{win: 2'b01, scores: {6'd12, 6'd8, 6'd14}});
      press(1'b0, 1'b1);
      finish_round(4'd4);
      chk("done", {31'd0, done}, 32'd1);

      press(1'b1, 1'b0);
      press(1'b0, 1'b1);
      repeat (3) @(negedge clk);
      chk("done_hold", {26'd0, done, card_req, result_vld, game_cnt[2:0]}, {26'd0, 3'b100, 3'd4});
      chk("done_cnt", {28'd0, game_cnt}, 32'd4);
      chk("sb_drained", sb_q.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, %0d checks done", n_checks);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1, "timeout");
   end

endmodule
